// File: rtl/instr_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_resp
// Brief    : Instruction-fetch responder. Synchronous program memory with a load
//            port, one-cycle read stage and an output FIFO toward decode, with
//            flush, stall and sticky overflow reporting. Optional word parity
//            is enabled by defining INSTR_MEM_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_resp #(
    parameter int              XLEN       = 32,
    parameter int              MEM_DEPTH  = 1024,
    parameter int              ADDR_W     = 10,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [XLEN-1:0]   pc,
    input  logic              taken_branch,
    input  logic              flush,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [XLEN-1:0]   ld_data,
    input  logic              instr_ready,
    output logic              instr_valid,
    output logic [XLEN-1:0]   instr,
    output logic [XLEN-1:0]   instr_pc,
    output logic              instr_taken_branch,
    output logic              instr_addr_err,
`ifdef INSTR_MEM_PARITY_EN
    output logic              instr_par_err,
`endif
    output logic              stall_req,
    output logic              overflow_err
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
`ifdef INSTR_MEM_PARITY_EN
    localparam int c_WORD_W = XLEN + 1;
`else
    localparam int c_WORD_W = XLEN;
`endif

    // ------------------------------------------------------------------
    // Program memory and read stage
    // ------------------------------------------------------------------
    logic [c_WORD_W-1:0] r_mem [MEM_DEPTH];
    logic [c_WORD_W-1:0] r_rs_word;
    logic [c_WORD_W-1:0] w_ld_word;
    logic [XLEN-1:0]     r_rs_pc;
    logic                r_rs_tb;
    logic                r_rs_err;
    logic                r_rs_valid;
    logic                w_pc_err;
    logic [XLEN-1:0]     w_push_data;
    logic                w_push_par;

    assign w_pc_err = |pc[XLEN-1:ADDR_W];

`ifdef INSTR_MEM_PARITY_EN
    // Stored bit makes the total number of ones even.
    assign w_ld_word   = {^ld_data, ld_data};
    assign w_push_par  = ^r_rs_word;
`else
    assign w_ld_word   = ld_data;
    assign w_push_par  = 1'b0;
`endif
    assign w_push_data = (r_rs_err | w_push_par) ? NOP_INSTR : r_rs_word[XLEN-1:0];

    // Non-blocking write and read on the same edge give read-first behaviour.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            r_mem[ld_addr] <= w_ld_word;
        end
        r_rs_word <= r_mem[pc[ADDR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rs_valid <= 1'b0;
            r_rs_pc    <= '0;
            r_rs_tb    <= 1'b0;
            r_rs_err   <= 1'b0;
        end else begin
            r_rs_valid <= rd_en & ~flush;
            if (rd_en) begin
                r_rs_pc  <= pc;
                r_rs_tb  <= taken_branch;
                r_rs_err <= w_pc_err;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [XLEN-1:0]       r_fifo_data [FIFO_DEPTH];
    logic [XLEN-1:0]       r_fifo_pc   [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_fifo_tb;
    logic [FIFO_DEPTH-1:0] r_fifo_err;
    logic [FIFO_DEPTH-1:0] r_fifo_par;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_overflow;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;

    assign w_full = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_pop  = instr_valid & instr_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
    assign w_push = r_rs_valid & (~w_full | w_pop);
    assign w_drop = r_rs_valid & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= w_push_data;
            r_fifo_pc[r_wr_ptr]   <= r_rs_pc;
            r_fifo_tb[r_wr_ptr]   <= r_rs_tb;
            r_fifo_err[r_wr_ptr]  <= r_rs_err;
            r_fifo_par[r_wr_ptr]  <= w_push_par;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: head fields read as zero while the FIFO is empty
    // ------------------------------------------------------------------
    assign instr_valid        = (r_count != '0);
    assign instr              = instr_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign instr_pc           = instr_valid ? r_fifo_pc[r_rd_ptr]   : '0;
    assign instr_taken_branch = instr_valid & r_fifo_tb[r_rd_ptr];
    assign instr_addr_err     = instr_valid & r_fifo_err[r_rd_ptr];
`ifdef INSTR_MEM_PARITY_EN
    assign instr_par_err      = instr_valid & r_fifo_par[r_rd_ptr];
`endif
    // Two slots of headroom cover the registered fetch halt plus the read stage.
    assign stall_req    = (r_count + {{c_PTR_W{1'b0}}, r_rs_valid}) >= c_CNT_W'(FIFO_DEPTH - 2);
    assign overflow_err = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_resp
// Brief    : Self-checking bench for instr_mem_resp: queue-based reference model
//            compared every cycle, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_resp;

    localparam int c_XLEN  = 32;
    localparam int c_DEPTH = 1024;
    localparam int c_AW    = 10;
    localparam int c_FD    = 4;
    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst_n, rd_en, taken_branch, flush, ld_en, instr_ready;
    logic [31:0]     pc, ld_data;
    logic [c_AW-1:0] ld_addr;
    logic            instr_valid, instr_taken_branch, instr_addr_err, stall_req, overflow_err;
    logic [31:0]     instr, instr_pc;
`ifdef INSTR_MEM_PARITY_EN
    logic            instr_par_err;
`endif

    instr_mem_resp #(
        .XLEN(c_XLEN), .MEM_DEPTH(c_DEPTH), .ADDR_W(c_AW),
        .FIFO_DEPTH(c_FD), .NOP_INSTR(c_NOP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .pc(pc),
        .taken_branch(taken_branch), .flush(flush), .ld_en(ld_en),
        .ld_addr(ld_addr), .ld_data(ld_data), .instr_ready(instr_ready),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_taken_branch(instr_taken_branch), .instr_addr_err(instr_addr_err),
`ifdef INSTR_MEM_PARITY_EN
        .instr_par_err(instr_par_err),
`endif
        .stall_req(stall_req), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
        logic        tb;
        logic        err;
        logic        par;
    } ent_t;

    ent_t        q[$];
    ent_t        m_rs;
    bit          m_rs_v = 1'b0;
    bit          m_ovf  = 1'b0;
    logic [31:0] m_mem [c_DEPTH];
    bit          m_bad [c_DEPTH];

    always @(posedge clk) begin
        bit pop, full;
        if (!rst_n) begin
            m_rs_v = 1'b0;
            q.delete();
            m_ovf  = 1'b0;
        end else if (flush) begin
            m_rs_v = 1'b0;
            q.delete();
        end else begin
            pop  = (q.size() != 0) && instr_ready;
            full = (q.size() == c_FD);
            if (pop) void'(q.pop_front());
            if (m_rs_v) begin
                if (full && !pop) m_ovf = 1'b1;
                else              q.push_back(m_rs);
            end
            m_rs_v = rd_en;
            if (rd_en) begin
                m_rs.pc   = pc;
                m_rs.tb   = taken_branch;
                m_rs.err  = (pc >= 32'(c_DEPTH));
                m_rs.par  = m_bad[pc[c_AW-1:0]];
                m_rs.data = (m_rs.err || m_rs.par) ? c_NOP : m_mem[pc[c_AW-1:0]];
            end
        end
        // Load lands after the read above: read-first.
        if (ld_en) begin
            m_mem[ld_addr] = ld_data;
            m_bad[ld_addr] = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (chk_en) begin
            #1;
            chk("m_valid", instr_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("m_instr", instr, q[0].data);
                chk("m_pc", instr_pc, q[0].pc);
                chk("m_tb", instr_taken_branch, q[0].tb);
                chk("m_err", instr_addr_err, q[0].err);
`ifdef INSTR_MEM_PARITY_EN
                chk("m_par", instr_par_err, q[0].par);
`endif
            end
            chk("m_stall", stall_req, (q.size() + int'(m_rs_v)) >= c_FD - 2);
            chk("m_ovf", overflow_err, m_ovf);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic expect_head(input string tag, input logic [31:0] d, input logic [31:0] p,
                               input logic tb, input logic er, input logic pe);
        chk({tag, "_valid"}, instr_valid, 1);
        chk({tag, "_instr"}, instr, d);
        chk({tag, "_pc"}, instr_pc, p);
        chk({tag, "_tb"}, instr_taken_branch, tb);
        chk({tag, "_err"}, instr_addr_err, er);
`ifdef INSTR_MEM_PARITY_EN
        chk({tag, "_par"}, instr_par_err, pe);
`else
        if (pe) chk({tag, "_par_unexpected"}, 1, 0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; rd_en = 1'b0; pc = '0; taken_branch = 1'b0; flush = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        chk("rst_tb", instr_taken_branch, 0);
        chk("rst_err", instr_addr_err, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_ovf", overflow_err, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            ld_en = 1'b1; ld_addr = c_AW'(i); ld_data = 32'hA0 + 32'(i);
            @(negedge clk);
        end
        ld_en = 1'b0;

        // Streaming reads with decode always ready: one result per cycle, no gaps.
        instr_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k >= 2 && k < 6) expect_head("stream", 32'hA0 + 32'(k - 2), 32'(k - 2), 0, 0, 0);
            else                 chk("stream_empty", instr_valid, 0);
            if (k < 4) begin rd_en = 1'b1; pc = 32'(k); end
            else       rd_en = 1'b0;
            @(negedge clk);
        end

        // Back-pressure: four requests fill the FIFO exactly.
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) chk("bp_stall_lo", stall_req, 0);
            if (k == 2) chk("bp_stall_hi", stall_req, 1);
            if (k < 4) begin rd_en = 1'b1; pc = 32'(k); end
            else       rd_en = 1'b0;
            @(negedge clk);
        end
        chk("bp_full_stall", stall_req, 1);
        chk("bp_no_ovf", overflow_err, 0);
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expect_head("drain", 32'hA0 + 32'(k), 32'(k), 0, 0, 0);
            @(negedge clk);
        end
        chk("drain_empty", instr_valid, 0);

        // Flush with three buffered entries and a same-cycle request.
        instr_ready = 1'b0;
        for (int k = 4; k < 7; k++) begin
            rd_en = 1'b1; pc = 32'(k);
            @(negedge clk);
        end
        rd_en = 1'b0;
        @(negedge clk);
        expect_head("pre_flush", 32'hA4, 32'd4, 0, 0, 0);
        chk("pre_flush_stall", stall_req, 1);
        flush = 1'b1; rd_en = 1'b1; pc = 32'd7;
        @(negedge clk);
        chk("flush_valid", instr_valid, 0);
        chk("flush_stall", stall_req, 0);
        flush = 1'b0; rd_en = 1'b1; pc = 32'd2; taken_branch = 1'b1; instr_ready = 1'b1;
        @(negedge clk);
        chk("target_wait", instr_valid, 0);
        rd_en = 1'b0; taken_branch = 1'b0;
        @(negedge clk);
        expect_head("target", 32'hA2, 32'd2, 1, 0, 0);
        @(negedge clk);
        chk("target_only", instr_valid, 0);

        // Out-of-range pc returns the NOP word with the address error tag.
        rd_en = 1'b1; pc = 32'(c_DEPTH + 5);
        @(negedge clk);
        rd_en = 1'b0;
        @(negedge clk);
        expect_head("oor", c_NOP, 32'(c_DEPTH + 5), 0, 1, 0);
        @(negedge clk);

        // Load and read of the same word in one cycle: old data first.
        ld_en = 1'b1; ld_addr = 10'd1; ld_data = 32'hBB; rd_en = 1'b1; pc = 32'd1;
        @(negedge clk);
        ld_en = 1'b0;
        @(negedge clk);
        rd_en = 1'b0;
        expect_head("rf_old", 32'hA1, 32'd1, 0, 0, 0);
        @(negedge clk);
        expect_head("rf_new", 32'hBB, 32'd1, 0, 0, 0);
        @(negedge clk);

        // Overflow: a fifth entry with decode stalled is dropped.
        instr_ready = 1'b0;
        for (int k = 8; k < 13; k++) begin
            rd_en = 1'b1; pc = 32'(k);
            @(negedge clk);
        end
        rd_en = 1'b0;
        @(negedge clk);
        chk("ovf_set", overflow_err, 1);
        instr_ready = 1'b1;
        for (int k = 8; k < 12; k++) begin
            expect_head("ovf_keep", 32'hA0 + 32'(k), 32'(k), 0, 0, 0);
            @(negedge clk);
        end
        chk("ovf_drained", instr_valid, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("ovf_sticky", overflow_err, 1);

`ifdef INSTR_MEM_PARITY_EN
        dut.r_mem[2][c_XLEN] <= ~dut.r_mem[2][c_XLEN];
        m_bad[2] = 1'b1;
        for (int k = 1; k < 6; k++) begin
            if (k < 4) begin rd_en = 1'b1; pc = 32'(k); end
            else       rd_en = 1'b0;
            @(negedge clk);
        end
        rd_en = 1'b0;
`endif

        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_ovf", overflow_err, 0);
        chk("rst2_valid", instr_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

`ifdef INSTR_MEM_PARITY_EN
    // Literal pins for the parity sequence: pc 1 clean, pc 2 corrupted, pc 3 clean.
    initial begin
        wait (m_bad[2]);
        @(negedge clk); @(negedge clk);
        expect_head("par_pc1", 32'hBB, 32'd1, 0, 0, 0);
        @(negedge clk);
        expect_head("par_pc2", c_NOP, 32'd2, 0, 0, 1);
        @(negedge clk);
        expect_head("par_pc3", 32'hA3, 32'd3, 0, 0, 0);
    end
`endif

endmodule
`default_nettype wire
